if_stage: RTL
=============

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  in  1  synchronous, active-low reset.
REQ-004 Port: stall_i  in  1  hazard unit request to hold the IF/ID outputs and PC.
REQ-005 Port: flush_i  in  1  taken branch/jump resolved in EX; discard in-flight fetch.
REQ-006 Port: redirect_pc_i  in  32  branch/jump target, sampled when flush_i=1.
REQ-007 Port: imem_req_o  out  1  instruction memory read request.
REQ-008 Port: imem_addr_o  out  32  request address, word aligned.
REQ-009 Port: imem_rvalid_i  in  1  response valid, exactly one cycle after the accepted request.
REQ-010 Port: imem_rdata_i  in  32  instruction word.
REQ-011 Ports: pc_out (out, 32), instr_out (out, 32), valid_out (out, 1) = IF/ID register contents feeding the decode stage and the ID/EX register.

Function
REQ-012 FSM states SHALL be BOOT, RUN and HOLD.
REQ-013 BOOT SHALL assert imem_req_o with imem_addr_o=pc_reg for one cycle, then go to RUN.
REQ-014 In RUN, with imem_rvalid_i=1 and stall_i=0, the block SHALL load pc_out=addr of that request, instr_out=imem_rdata_i and valid_out=1, set pc_reg+=4 and request the new pc_reg in the same cycle.
REQ-015 In RUN, with imem_rvalid_i=1 and stall_i=1, the block SHALL capture the response into the skid buffer, deassert imem_req_o, hold the IF/ID outputs and go to HOLD.
REQ-016 In HOLD, stall_i=0 SHALL move the skid buffer into the IF/ID outputs, request pc_reg, and go to RUN; stall_i=1 SHALL keep all state.
REQ-017 flush_i SHALL have priority over stall_i and every other event: valid_out<=0, instr_out<=NOP (32'h0000_0013), skid buffer cleared, any in-flight response dropped, pc_reg<={redirect_pc_i[31:2],2'b00}, next state BOOT.
REQ-018 A response arriving in the cycle after a flush SHALL be ignored, tracked by a one-bit kill flag.
REQ-019 pc_reg increment SHALL wrap modulo 2^32 (32'hFFFF_FFFC+4=0).
REQ-020 Fetch latency SHALL be 2 cycles from request issue to valid_out; steady state without stall SHALL deliver one instruction per cycle.
REQ-021 imem_req_o SHALL never be asserted while the skid buffer holds an instruction.

Reset
REQ-022 While rst_n=0 at a clock edge: pc_reg=RESET_PC, pc_out=0, instr_out=NOP, valid_out=0, imem_req_o=0, skid buffer empty, kill flag=0, state=BOOT.
REQ-023 A reset asserted mid-operation SHALL override flush and stall and discard any outstanding response.

Configuration
REQ-024 Macro IF_PERF_CNT_EN: when defined, add 32-bit outputs fetch_cnt_o (counts valid_out loads) and bubble_cnt_o (counts cycles with valid_out=0 after BOOT). Both SHALL reset to 0 and wrap. When undefined, these ports and counters SHALL be absent and behaviour otherwise identical.

Structure
REQ-025 Shared package if_pkg SHALL hold the NOP constant, the FSM state enum and the RESET_PC default.
REQ-026 The skid buffer (pc, instr, full flag; load/drain/clear) SHALL be a sub-module if_skid_buf.

Verification
REQ-027 Reset release, RESET_PC=0, memory returns words at 0,4,8 -> first request at 0; valid_out=1 with pc_out=0 two cycles later; then pc_out 4, 8 on consecutive cycles.
REQ-028 stall_i=1 for 3 cycles when the response for 0x8 returns -> IF/ID outputs hold 0x4, no imem_req_o; release -> pc_out=0x8 next cycle, request 0xC.
REQ-029 flush_i=1 with redirect_pc_i=0x100 while a request for 0x10 is in flight -> valid_out=0 next cycle, 0x10 response dropped, next request at 0x100.
REQ-030 flush_i and stall_i both 1 with redirect 0x203 -> flush wins, request at 0x200, skid empty.
REQ-031 pc_reg=0xFFFF_FFFC with no stall -> next request at 0x0000_0000.
REQ-032 With IF_PERF_CNT_EN, 10 fetches including one 2-cycle stall -> fetch_cnt_o=10; reset -> both counters 0.

Source files
------------

// File: rtl/if_pkg.sv
// Shared definitions for the instruction fetch stage: NOP encoding,
// FSM state enum, default reset PC and a word-alignment helper.
package if_pkg;

    localparam logic [31:0] NOP              = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } if_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry skid buffer: parks a fetch response that arrived while decode
// was stalled. clear has priority over load, load over drain.
module if_skid_buf
    import if_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        drain_i,
    input  logic        clear_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    output logic        full_o,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o
);

    logic        full_q, full_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;

    // next-state: clear / load / drain
    always_comb begin
        full_d  = full_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (clear_i) begin
            full_d  = 1'b0;
            instr_d = NOP;
        end else if (load_i) begin
            full_d  = 1'b1;
            pc_d    = pc_i;
            instr_d = instr_i;
        end else if (drain_i) begin
            full_d  = 1'b0;
        end
    end

    // buffer registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_q  <= 1'b0;
            pc_q    <= 32'h0;
            instr_q <= NOP;
        end else begin
            full_q  <= full_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign full_o  = full_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage with IF/ID register, one-entry skid buffer and
// flush redirect. pc_reg tracks the address of the most recent request, so
// a response is always tagged with pc_reg. The next request is issued in
// the same cycle a response is consumed, giving one instruction per cycle.
// Optional performance counters are enabled by defining IF_PERF_CNT_EN.
module if_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
`ifdef IF_PERF_CNT_EN
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] bubble_cnt_o,
`endif
    output logic [31:0] pc_out,
    output logic [31:0] instr_out,
    output logic        valid_out
);

    if_state_e   state_q, state_d;
    logic [31:0] pc_reg_q, pc_reg_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic        kill_q, kill_d;

    logic        skid_load, skid_drain, skid_clear, skid_full;
    logic [31:0] skid_pc, skid_instr;
    logic        req, load, rsp;
    logic [31:0] addr;
    logic [1:0]  unused_redirect_bits;

    assign unused_redirect_bits = redirect_pc_i[1:0];

    // a response in the cycle right after a flush belongs to the old path
    assign rsp = imem_rvalid_i & ~kill_q;

    if_skid_buf u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (skid_load),
        .drain_i (skid_drain),
        .clear_i (skid_clear),
        .pc_i    (pc_reg_q),
        .instr_i (imem_rdata_i),
        .full_o  (skid_full),
        .pc_o    (skid_pc),
        .instr_o (skid_instr)
    );

    // FSM next state, IF/ID load, skid control and request generation
    always_comb begin
        state_d    = state_q;
        pc_reg_d   = pc_reg_q;
        pc_out_d   = pc_out_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
        kill_d     = 1'b0;
        skid_load  = 1'b0;
        skid_drain = 1'b0;
        skid_clear = 1'b0;
        req        = 1'b0;
        load       = 1'b0;
        addr       = pc_reg_q;
        if (flush_i) begin
            // no request during a flush: the target is fetched from BOOT
            valid_d    = 1'b0;
            instr_d    = NOP;
            skid_clear = 1'b1;
            pc_reg_d   = word_align(redirect_pc_i);
            kill_d     = 1'b1;
            state_d    = BOOT;
        end else begin
            case (state_q)
                BOOT: begin
                    req     = 1'b1;
                    state_d = RUN;
                    if (!stall_i) valid_d = 1'b0;
                end
                RUN: begin
                    if (rsp && !stall_i) begin
                        load     = 1'b1;
                        pc_out_d = pc_reg_q;
                        instr_d  = imem_rdata_i;
                        pc_reg_d = pc_reg_q + 32'd4;
                        req      = 1'b1;
                        addr     = pc_reg_d;
                    end else if (rsp) begin
                        skid_load = 1'b1;
                        pc_reg_d  = pc_reg_q + 32'd4;
                        state_d   = HOLD;
                    end else if (!stall_i) begin
                        valid_d = 1'b0;
                    end
                end
                HOLD: begin
                    // the skid entry leaves at this edge, so its slot is free
                    // for the response to the request issued now
                    if (!stall_i) begin
                        load       = 1'b1;
                        skid_drain = 1'b1;
                        pc_out_d   = skid_pc;
                        instr_d    = skid_instr;
                        req        = 1'b1;
                        state_d    = RUN;
                    end
                end
                default: state_d = BOOT;
            endcase
            if (load) valid_d = 1'b1;
        end
    end

    // request is suppressed while the skid holds an undrained entry and in reset
    assign imem_req_o  = req & rst_n & (~skid_full | skid_drain);
    assign imem_addr_o = addr;

    // state and IF/ID registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= BOOT;
            pc_reg_q <= word_align(RESET_PC);
            pc_out_q <= 32'h0;
            instr_q  <= NOP;
            valid_q  <= 1'b0;
            kill_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_reg_q <= pc_reg_d;
            pc_out_q <= pc_out_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            kill_q   <= kill_d;
        end
    end

    assign pc_out    = pc_out_q;
    assign instr_out = instr_q;
    assign valid_out = valid_q;

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    // fetches count IF/ID loads, bubbles count empty IF/ID cycles outside BOOT
    always_comb begin
        fetch_cnt_d  = fetch_cnt_q + {31'd0, load};
        bubble_cnt_d = bubble_cnt_q + {31'd0, (~valid_q && (state_q != BOOT))};
    end

    // counter registers, wrap naturally
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_cnt_q  <= 32'h0;
            bubble_cnt_q <= 32'h0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign fetch_cnt_o  = fetch_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule
